// File: rtl/seq_multiplier_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package seq_multiplier_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of an iteration counter that must hold n-1; never below one bit.
   function automatic int count_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_multiplier_counter.sv
// Down-counter tracking the remaining shift-add iterations.
module seq_multiplier_counter #(
   parameter int COUNT_WIDTH = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   do_preset,
   input  logic [COUNT_WIDTH-1:0] preset_value,
   input  logic                   do_decrement,
   output logic                   is_zero
);

   logic [COUNT_WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (do_preset)
         count_d = preset_value;
      else if (do_decrement)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign is_zero = (count_q == '0);

endmodule

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one iteration per multiplier bit, signed or unsigned,
// result held under a valid/accept handshake.
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int A_WIDTH = 8,
   parameter int B_WIDTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       is_signed,
   input  logic [A_WIDTH-1:0]         multiplicand,
   input  logic [B_WIDTH-1:0]         multiplier,
   output logic                       ready,
   output logic [A_WIDTH+B_WIDTH-1:0] product,
   output logic                       product_valid,
   input  logic                       product_accept
);

   localparam int CW = count_width(B_WIDTH);
   localparam int PW = A_WIDTH + B_WIDTH;
   localparam logic [CW-1:0] LAST_ITER = CW'(B_WIDTH - 1);

   state_t             state_q, state_d;
   logic [A_WIDTH:0]   acc_q, acc_d;
   logic [B_WIDTH-1:0] mreg_q, mreg_d;
   logic [A_WIDTH-1:0] mcand_q, mcand_d;
   logic               signed_q, signed_d;
   logic [PW-1:0]      product_q, product_d;
   logic               ready_q, ready_d;
   logic               valid_q, valid_d;

   logic               do_preset, do_decrement, cnt_zero;
   logic [A_WIDTH+1:0] mcand_ext, acc_ext, sum;
   logic [A_WIDTH:0]   acc_next;
   logic [B_WIDTH-1:0] mreg_next;

   seq_multiplier_counter #(.COUNT_WIDTH(CW)) u_counter (
      .clock        (clock),
      .reset        (reset),
      .do_preset    (do_preset),
      .preset_value (LAST_ITER),
      .do_decrement (do_decrement),
      .is_zero      (cnt_zero)
   );

   // Sum is two bits wider than the multiplicand so neither a signed
   // subtract nor an unsigned carry can overflow before the shift.
   always_comb begin
      mcand_ext = signed_q ? {{2{mcand_q[A_WIDTH-1]}}, mcand_q} : {2'b00, mcand_q};
      acc_ext   = signed_q ? {acc_q[A_WIDTH], acc_q} : {1'b0, acc_q};
      sum       = acc_ext;
      if (mreg_q[0])
         sum = (signed_q && cnt_zero) ? acc_ext - mcand_ext : acc_ext + mcand_ext;
      acc_next  = sum[A_WIDTH+1:1];
      mreg_next = {sum[0], mreg_q[B_WIDTH-1:1]};
   end

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      mreg_d       = mreg_q;
      mcand_d      = mcand_q;
      signed_d     = signed_q;
      product_d    = product_q;
      ready_d      = ready_q;
      valid_d      = valid_q;
      do_preset    = 1'b0;
      do_decrement = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            mcand_d   = multiplicand;
            mreg_d    = multiplier;
            signed_d  = is_signed;
            acc_d     = '0;
            do_preset = 1'b1;
            ready_d   = 1'b0;
            state_d   = RUN;
         end
         RUN: begin
            acc_d  = acc_next;
            mreg_d = mreg_next;
            if (cnt_zero) begin
               product_d = {acc_next[A_WIDTH-1:0], mreg_next};
               valid_d   = 1'b1;
               state_d   = DONE;
            end else begin
               do_decrement = 1'b1;
            end
         end
         DONE: if (product_accept) begin
            valid_d = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
         end
         default: begin
            valid_d = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mreg_q    <= '0;
         mcand_q   <= '0;
         signed_q  <= 1'b0;
         product_q <= '0;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mreg_q    <= mreg_d;
         mcand_q   <= mcand_d;
         signed_q  <= signed_d;
         product_q <= product_d;
         ready_q   <= ready_d;
         valid_q   <= valid_d;
      end
   end

   assign ready         = ready_q;
   assign product       = product_q;
   assign product_valid = valid_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: 8x8 and 8x4 instances, directed table, corner sequences, random vs '*'.
module tb_seq_multiplier;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        sel = 1'b0;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [7:0]  mcand = '0;
   logic [7:0]  mplier = '0;
   logic        accept = 1'b0;

   logic        rdy8, vld8, rdy4, vld4;
   logic [15:0] prod8;
   logic [11:0] prod4;
   logic        cur_ready, cur_valid;
   logic [15:0] cur_product;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   seq_multiplier #(.A_WIDTH(8), .B_WIDTH(8)) u_dut8 (
      .clock(clock), .reset(reset), .start(start && !sel), .is_signed(is_signed),
      .multiplicand(mcand), .multiplier(mplier), .ready(rdy8), .product(prod8),
      .product_valid(vld8), .product_accept(accept && !sel)
   );

   seq_multiplier #(.A_WIDTH(8), .B_WIDTH(4)) u_dut4 (
      .clock(clock), .reset(reset), .start(start && sel), .is_signed(is_signed),
      .multiplicand(mcand), .multiplier(mplier[3:0]), .ready(rdy4), .product(prod4),
      .product_valid(vld4), .product_accept(accept && sel)
   );

   always_comb begin
      cur_ready   = sel ? rdy4 : rdy8;
      cur_valid   = sel ? vld4 : vld8;
      cur_product = sel ? {4'h0, prod4} : prod8;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: interpret operands at their widths, multiply, wrap to aw+bw bits.
   function automatic logic [15:0] ref_mul(input bit sg, input logic [7:0] a, input logic [7:0] b,
                                           input int aw, input int bw);
      longint av, bv, p;
      av = longint'(a) & ((64'sd1 <<< aw) - 1);
      bv = longint'(b) & ((64'sd1 <<< bw) - 1);
      if (sg && av[aw-1]) av = av - (64'sd1 <<< aw);
      if (sg && bv[bw-1]) bv = bv - (64'sd1 <<< bw);
      p = (av * bv) & ((64'sd1 <<< (aw + bw)) - 1);
      return p[15:0];
   endfunction

   // Issue one op, measure edges from acceptance to valid, then accept it.
   task automatic run_op(input bit s, input bit sg, input logic [7:0] a, input logic [7:0] b,
                         input bit early, output logic [15:0] p, output int lat, output int t0);
      int n;
      n = 0;
      sel = s;
      while (!cur_ready && n < 50) begin @(posedge clock); #1; n++; end
      if (!cur_ready) chk("ready_timeout", 32'(cur_ready), 32'd1);
      is_signed = sg; mcand = a; mplier = b; start = 1'b1; accept = early;
      @(posedge clock); #1;
      t0 = cyc;
      start = 1'b0;
      lat = 0;
      while (!cur_valid && lat < 50) begin @(posedge clock); #1; lat++; end
      p = cur_product;
      accept = 1'b1;
      @(posedge clock); #1;
      accept = 1'b0;
   endtask

   typedef struct {
      string      name;
      bit         sel;
      bit         sg;
      logic [7:0] a;
      logic [7:0] b;
      logic [15:0] exp;
      int         lat;
   } vec_t;

   vec_t vt[5];

   initial begin
      logic [15:0] p, held;
      int lat, t0, prev_t0, prev_lat;

      vt[0] = '{"u255x255",  1'b0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 8};
      vt[1] = '{"s-128x-128", 1'b0, 1'b1, 8'h80, 8'h80, 16'h4000, 8};
      vt[2] = '{"s-1x127",   1'b0, 1'b1, 8'hFF, 8'h7F, 16'hFF81, 8};
      vt[3] = '{"s5x-8_b4",  1'b1, 1'b1, 8'h05, 8'h08, 16'h0FD8, 4};
      vt[4] = '{"u5x8_b4",   1'b1, 1'b0, 8'h05, 8'h08, 16'h0028, 4};

      repeat (2) @(negedge clock);
      chk("rst_ready8", 32'(rdy8), 32'd1);
      chk("rst_valid8", 32'(vld8), 32'd0);
      chk("rst_prod8", 32'(prod8), 32'd0);
      chk("rst_ready4", 32'(rdy4), 32'd1);
      chk("rst_valid4", 32'(vld4), 32'd0);
      chk("rst_prod4", 32'(prod4), 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      prev_t0 = 0; prev_lat = 0;
      for (int i = 0; i < 5; i++) begin
         run_op(vt[i].sel, vt[i].sg, vt[i].a, vt[i].b, 1'b0, p, lat, t0);
         chk({vt[i].name, "_prod"}, 32'(p), 32'(vt[i].exp));
         chk({vt[i].name, "_lat"}, 32'(lat), 32'(vt[i].lat));
         if (i > 0) chk({vt[i].name, "_interval"}, 32'(t0 - prev_t0), 32'(prev_lat + 2));
         prev_t0 = t0; prev_lat = vt[i].lat;
      end

      // Backpressure, with operand churn and ignored starts during RUN and DONE.
      sel = 1'b0;
      is_signed = 1'b0; mcand = 8'd100; mplier = 8'd37; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      lat = 0;
      while (!vld8 && lat < 50) begin
         mcand = 8'($urandom); mplier = 8'($urandom); is_signed = 1'($urandom);
         start = lat[0];
         @(posedge clock); #1; lat++;
      end
      start = 1'b0;
      chk("bp_lat", 32'(lat), 32'd8);
      held = prod8;
      chk("bp_prod", 32'(held), 32'h0E74);
      for (int k = 0; k < 20; k++) begin
         start = k[0]; mcand = 8'($urandom); mplier = 8'($urandom);
         @(posedge clock); #1;
         chk("bp_hold_prod", 32'(prod8), 32'(held));
         chk("bp_hold_valid", 32'(vld8), 32'd1);
         chk("bp_hold_ready", 32'(rdy8), 32'd0);
      end
      start = 1'b0; accept = 1'b1;
      @(posedge clock); #1;
      accept = 1'b0;
      chk("bp_release_ready", 32'(rdy8), 32'd1);
      chk("bp_release_valid", 32'(vld8), 32'd0);
      chk("bp_prod_kept_idle", 32'(prod8), 32'(held));

      // Asynchronous reset in the third RUN cycle.
      is_signed = 1'b0; mcand = 8'd200; mplier = 8'd200; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_ready", 32'(rdy8), 32'd1);
      chk("rst_mid_valid", 32'(vld8), 32'd0);
      chk("rst_mid_prod", 32'(prod8), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      run_op(1'b0, 1'b0, 8'd3, 8'd7, 1'b0, p, lat, t0);
      chk("post_rst_3x7", 32'(p), 32'h0015);
      chk("post_rst_lat", 32'(lat), 32'd8);

      // Randomised against plain multiplication, both configurations.
      for (int cfg = 0; cfg < 2; cfg++) begin
         for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            bit sg, early;
            a = 8'($urandom); b = 8'($urandom); sg = 1'($urandom); early = 1'($urandom);
            if (cfg == 1) b[7:4] = 4'($urandom);
            run_op(cfg[0], sg, a, b, early, p, lat, t0);
            chk("rand_prod", 32'(p), 32'(ref_mul(sg, a, b, 8, cfg == 1 ? 4 : 8)));
            chk("rand_lat", 32'(lat), cfg == 1 ? 32'd4 : 32'd8);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier, the successor to the fixed-width four-bit unit. Independent operand widths, per-operation signed/unsigned mode, and a registered result with a valid/accept handshake so the consumer can stall. It sits between an operand source that issues `start` and a result consumer, and computes one product per operation in B_WIDTH iteration cycles.

## Interface
- `A_WIDTH`, default 8: multiplicand width in bits, ≥ 2.
- `B_WIDTH`, default 8: multiplier width in bits, ≥ 2. Sets the iteration count.
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high. Forces all state and outputs to reset values.
- `start`, in, 1: begin an operation. Sampled only while `ready`=1.
- `is_signed`, in, 1: 1 = two's-complement operands; 0 = unsigned. Captured with `start`.
- `multiplicand`, in, A_WIDTH: captured on the accepted `start` edge.
- `multiplier`, in, B_WIDTH: captured on the accepted `start` edge.
- `ready`, out, 1: high in IDLE only.
- `product`, out, A_WIDTH+B_WIDTH: result register.
- `product_valid`, out, 1: high in DONE only.
- `product_accept`, in, 1: consumer takes the result. Sampled only in DONE.

## Operation
- States are IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE:** `ready`=1.
  - `start`=1 → latch operands and `is_signed`, clear the accumulator, preset the counter to B_WIDTH-1, go to RUN.
  - `start`=0 → stay in IDLE.
- **RUN:** one iteration per cycle. Each iteration:
  - If the multiplier register LSB is 1, add the multiplicand to the upper accumulator part, which is A_WIDTH+1 bits wide. Unsigned mode zero-extends the multiplicand; signed mode sign-extends it.
  - In signed mode only, the final iteration (counter = 0) subtracts instead of adds, because the multiplier MSB has negative weight.
  - Shift the {accumulator, multiplier} right by one. Unsigned mode shifts in the carry bit; signed mode shifts arithmetically.
  - Decrement the counter.
  - The iteration with counter = 0 is the last one. It loads the low A_WIDTH+B_WIDTH bits into `product` and moves to DONE.
- **DONE:** `product_valid`=1 and `product` is held stable.
  - `product_accept`=1 → IDLE.
  - Otherwise stay in DONE indefinitely (backpressure).
- `start` outside IDLE is ignored. It is neither queued nor an error.
- `product_accept` outside DONE is ignored.
- Operand inputs have no effect except on the accepted `start` edge.
- `product` updates only on entry to DONE. It keeps its value through the following IDLE and RUN until the next DONE entry.
- Results are exact modulo 2^(A_WIDTH+B_WIDTH). This includes the signed most-negative × most-negative case, which is exact with no overflow.

## Timing
- Reset values: `ready`=1, `product_valid`=0, `product`=0, state IDLE, counter 0.
- `reset` asserted mid-RUN or mid-DONE aborts the operation immediately (asynchronous). No result is emitted and the block comes out of reset in IDLE.
- Latency:
  - `start` accepted at edge 0.
  - RUN spans edges 1..B_WIDTH.
  - `product_valid` rises after edge B_WIDTH.
- Fastest repeat:
  - `product_accept` at the first DONE edge returns the block to IDLE on that edge.
  - The next `start` can be accepted at the following edge.
  - Minimum issue interval is B_WIDTH+2 cycles.
- All outputs are registered or decoded from registered state only. There are no input-to-output combinational paths.

## Structure
- Package `seq_multiplier_pkg` holds:
  - `state_t`, an enum of IDLE, RUN and DONE.
  - A `clog2`-based counter-width function.
- Sub-module `seq_multiplier_counter`:
  - Parameter `COUNT_WIDTH`.
  - Inputs `do_preset` (with preset value) and `do_decrement`.
  - Output `is_zero`.
  - Same `clock`/`reset` as the parent.
- The top level holds the FSM and the datapath registers (accumulator of A_WIDTH+1 bits, multiplier shift register, multiplicand, mode bit, product).

## Test plan
- Unsigned, A=B=8, 255×255 → `product_valid` after exactly 8 cycles, `product`=0xFE01.
- Signed, A=B=8, -128×-128 → 0x4000. Then -1×127 → 0xFF81. Both are issued back-to-back at the minimum 10-cycle interval.
- Asymmetric, A_WIDTH=8, B_WIDTH=4:
  - signed 5×-8 → 0xFD8;
  - unsigned 5×8 → 0x028;
  - `product_valid` after 4 cycles.
- Backpressure: hold `product_accept`=0 for 20 cycles in DONE → `product` stable, `product_valid` held. `start` pulses during this time are ignored and `ready` stays 0. Operands changed during RUN do not alter the result.
- Reset mid-RUN (cycle 3 of 8) → `ready`=1, `product_valid`=0, `product`=0 immediately. A subsequent 3×7 unsigned → 0x0015.
- Randomised self-check: 1000 random operand/mode pairs per width configuration compared against a behavioural `*` model.
